onewire_slave_ds: RTL and testbench

ONEWIRE_SLAVE_DS -- requirements
Module: onewire_slave_ds

---
 rtl/onewire_slave_ds.sv | 237 +++++++++++++++++++++++
 tb/tb_onewire_slave_ds.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_slave_ds.sv
// 1-Wire slave modelling a DS18B20-style sensor: reset/presence,
// ROM skip, convert, read scratchpad. Byte 8 is CRC8 under ONEWIRE_CRC_EN.
// Ports: clk, rst_n, dq_in (line), dq_oe (pull low), temp_data,
//        busy, cmd_byte, cmd_stb.
module onewire_slave_ds #(
  parameter int FCLK    = 125,
  parameter int CONV_US = 750000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dq_in,
  output logic        dq_oe,
  input  logic [15:0] temp_data,
  output logic        busy,
  output logic [7:0]  cmd_byte,
  output logic        cmd_stb
);

  localparam int TW = (FCLK > 1) ? $clog2(FCLK) : 1;
  localparam int CW = (CONV_US > 1) ? $clog2(CONV_US) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FCLK - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_US - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PWAIT = 3'd1;
  localparam logic [2:0] S_PRES  = 3'd2;
  localparam logic [2:0] S_ROM   = 3'd3;
  localparam logic [2:0] S_FUNC  = 3'd4;
  localparam logic [2:0] S_TX    = 3'd5;

  logic          dq_s1, dq_s2, dq_prev;
  logic          fall, rise, tick, rst_pulse;
  logic [TW-1:0] tcnt;
  logic [8:0]    low_us;
  logic [2:0]    state;
  logic [6:0]    tmr;
  logic          slot_act;
  logic [5:0]    slot_us;
  logic [7:0]    sh, rx_byte;
  logic [2:0]    bitcnt;
  logic [6:0]    txbit;
  logic [7:0]    sp0, sp1, cur_byte, byte8;
  logic          cur_bit;
  logic [CW-1:0] conv_cnt;
  logic          byte_done, conv_go;

  assign fall      = dq_prev & ~dq_s2;
  assign rise      = ~dq_prev & dq_s2;
  assign tick      = (tcnt == TICK_LAST);
  assign rst_pulse = rise && (low_us >= 9'd480);
  assign rx_byte   = {dq_s2, sh[7:1]};
  assign byte_done = (state == S_ROM || state == S_FUNC)
                   && slot_act && tick
                   && slot_us == 6'd29 && bitcnt == 3'd7;
  assign conv_go   = !rst_pulse && byte_done
                   && state == S_FUNC && rx_byte == 8'h44;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_s1   <= 1'b1;
      dq_s2   <= 1'b1;
      dq_prev <= 1'b1;
      tcnt    <= '0;
      low_us  <= '0;
    end else begin
      dq_s1   <= dq_in;
      dq_s2   <= dq_s1;
      dq_prev <= dq_s2;
      tcnt    <= tick ? '0 : tcnt + 1'b1;
      if (dq_s2)
        low_us <= '0;
      else if (tick && low_us != 9'd480)
        low_us <= low_us + 9'd1;
    end
  end

  always_comb begin
    cur_byte = byte8;
    case (txbit[6:3])
      4'd0:    cur_byte = sp0;
      4'd1:    cur_byte = sp1;
      4'd2:    cur_byte = 8'h4B;
      4'd3:    cur_byte = 8'h46;
      4'd4:    cur_byte = 8'h7F;
      4'd5:    cur_byte = 8'hFF;
      4'd6:    cur_byte = 8'h0C;
      4'd7:    cur_byte = 8'h10;
      default: cur_byte = byte8;
    endcase
  end

  assign cur_bit = cur_byte[txbit[2:0]];

`ifdef ONEWIRE_CRC_EN
  logic [7:0] crc;
  logic       fb, tx_go, tx_fire;
  assign fb      = crc[0] ^ cur_bit;
  assign tx_go   = !rst_pulse && byte_done
                 && state == S_FUNC && rx_byte == 8'hBE;
  assign tx_fire = !rst_pulse && state == S_TX && !dq_oe && fall;
  assign byte8   = crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc <= '0;
    else if (tx_go)
      crc <= '0;
    else if (tx_fire && txbit < 7'd64)
      crc <= {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
  end
`else
  assign byte8 = 8'h00;
`endif

  // Conversion is not a bus transaction, so it keeps running
  // across reset pulses; only a new 0x44 restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      conv_cnt <= '0;
      sp0      <= 8'h50;
      sp1      <= 8'h05;
    end else if (conv_go) begin
      busy     <= 1'b1;
      conv_cnt <= '0;
    end else if (busy && tick) begin
      if (conv_cnt == CONV_LAST) begin
        busy <= 1'b0;
        sp0  <= temp_data[7:0];
        sp1  <= temp_data[15:8];
      end else begin
        conv_cnt <= conv_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tmr      <= '0;
      slot_act <= 1'b0;
      slot_us  <= '0;
      sh       <= '0;
      bitcnt   <= '0;
      txbit    <= '0;
      dq_oe    <= 1'b0;
      cmd_byte <= '0;
      cmd_stb  <= 1'b0;
    end else begin
      cmd_stb <= 1'b0;
      if (rst_pulse) begin
        state    <= S_PWAIT;
        tmr      <= '0;
        slot_act <= 1'b0;
        bitcnt   <= '0;
        txbit    <= '0;
        dq_oe    <= 1'b0;
      end else begin
        case (state)
          S_PWAIT: if (tick) begin
            if (tmr == 7'd29) begin
              state <= S_PRES;
              tmr   <= '0;
              dq_oe <= 1'b1;
            end else begin
              tmr <= tmr + 7'd1;
            end
          end
          S_PRES: if (tick) begin
            if (tmr == 7'd119) begin
              state <= S_ROM;
              tmr   <= '0;
              dq_oe <= 1'b0;
            end else begin
              tmr <= tmr + 7'd1;
            end
          end
          S_ROM, S_FUNC: begin
            if (slot_act) begin
              if (tick) begin
                if (slot_us == 6'd29) begin
                  slot_act <= 1'b0;
                  sh       <= rx_byte;
                  bitcnt   <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) begin
                    if (state == S_ROM) begin
                      state <= (rx_byte == 8'hCC)
                             ? S_FUNC : S_IDLE;
                    end else begin
                      cmd_byte <= rx_byte;
                      cmd_stb  <= 1'b1;
                      txbit    <= '0;
                      state    <= (rx_byte == 8'hBE)
                                ? S_TX : S_IDLE;
                    end
                  end
                end else begin
                  slot_us <= slot_us + 6'd1;
                end
              end
            end else if (fall) begin
              slot_act <= 1'b1;
              slot_us  <= '0;
            end
          end
          S_TX, S_IDLE: begin
            // Own drive masks falls until the 45 us hold ends.
            if (dq_oe) begin
              if (tick) begin
                if (slot_us == 6'd44)
                  dq_oe <= 1'b0;
                else
                  slot_us <= slot_us + 6'd1;
              end
            end else if (fall) begin
              if (state == S_TX) begin
                if (!cur_bit) begin
                  dq_oe   <= 1'b1;
                  slot_us <= '0;
                end
                if (txbit == 7'd71)
                  state <= S_IDLE;
                else
                  txbit <= txbit + 7'd1;
              end else if (busy) begin
                dq_oe   <= 1'b1;
                slot_us <= '0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onewire_slave_ds.sv
// Directed bench for onewire_slave_ds: bus master model on a
// wired-AND line, expected bytes and timings worked out by hand.
module tb_onewire_slave_ds;

  localparam int FCLK    = 2;
  localparam int CONV_US = 2500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mlow = 1'b0;
  logic [15:0] temp_data = 16'h0000;
  logic        dq_oe, busy, cmd_stb, dq_line;
  logic [7:0]  cmd_byte;

  assign dq_line = ~(mlow | dq_oe);

  always #5 clk = ~clk;

  onewire_slave_ds #(.FCLK(FCLK), .CONV_US(CONV_US)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dq_in(dq_line),
    .dq_oe(dq_oe),
    .temp_data(temp_data),
    .busy(busy),
    .cmd_byte(cmd_byte),
    .cmd_stb(cmd_stb)
  );

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int oe_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_stb === 1'b1) stb_cnt <= stb_cnt + 1;
    if (dq_oe === 1'b1) oe_cnt <= oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (n * FCLK) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    mlow = 1'b1;
    wait_us(b ? 5 : 60);
    mlow = 1'b0;
    wait_us(b ? 60 : 5);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    mlow = 1'b1;
    wait_us(2);
    mlow = 1'b0;
    wait_us(13);
    b = dq_line;
    wait_us(50);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  task automatic bus_reset(input int low, output int dly,
                           output int wid);
    mlow = 1'b1;
    wait_us(low);
    mlow = 1'b0;
    dly = -1;
    wid = 0;
    for (int i = 0; i < 200 * FCLK; i++) begin
      @(negedge clk);
      if (dq_oe === 1'b1) begin
        if (dly < 0) dly = i;
        wid++;
      end
    end
  endtask

  task automatic reset_ok(input string tag);
    int d, w;
    bus_reset(490, d, w);
    chk(tag, (w >= 238 && w <= 242) ? 1 : 0, 1);
  endtask

`ifdef ONEWIRE_CRC_EN
  function automatic logic [7:0] crc8(input logic [63:0] d);
    logic [7:0] c;
    logic       m;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      m = c[0] ^ d[i];
      c = {1'b0, c[7:1]};
      if (m) c = c ^ 8'h8C;
    end
    return c;
  endfunction
`endif

  logic [7:0] exp_sp [0:8];
  logic [7:0] v;
  logic       b;
  int         d, w, t_first, t2, tfall;

  initial begin
    exp_sp[0] = 8'h91; exp_sp[1] = 8'h01;
    exp_sp[2] = 8'h4B; exp_sp[3] = 8'h46;
    exp_sp[4] = 8'h7F; exp_sp[5] = 8'hFF;
    exp_sp[6] = 8'h0C; exp_sp[7] = 8'h10;
`ifdef ONEWIRE_CRC_EN
    exp_sp[8] = crc8(64'h10_0C_FF_7F_46_4B_01_91);
`else
    exp_sp[8] = 8'h00;
`endif

    repeat (3) @(negedge clk);
    chk("rst_oe", dq_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", cmd_byte, 8'h00);
    chk("rst_stb", cmd_stb, 0);
    rst_n = 1'b1;
    wait_us(10);

    oe_cnt = 0;
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(v);
    chk("pre_rd", v, 8'hFF);
    chk("pre_oe", oe_cnt, 0);
    chk("pre_cmd", cmd_byte, 8'h00);

    bus_reset(400, d, w);
    chk("short_wid", w, 0);

    bus_reset(490, d, w);
    chk("pres_dly", (d >= 56 && d <= 68) ? 1 : 0, 1);
    chk("pres_wid", (w >= 238 && w <= 242) ? 1 : 0, 1);

    write_byte(8'hCC);
    write_byte(8'hBE);
    chk("cmd_be", cmd_byte, 8'hBE);
    read_byte(v);
    chk("init_b0", v, 8'h50);
    read_byte(v);
    chk("init_b1", v, 8'h05);

    reset_ok("rst_a");
    temp_data = 16'h0191;
    write_byte(8'hCC);
    stb_cnt = 0;
    write_byte(8'h44);
    t_first = cyc;
    chk("cmd_44", cmd_byte, 8'h44);
    chk("stb_len", stb_cnt, 1);
    chk("busy_on", busy, 1);
    read_bit(b);
    chk("busy_rd0", b, 0);
    read_bit(b);
    chk("busy_rd1", b, 0);

    reset_ok("rst_b");
    write_byte(8'hCC);
    write_byte(8'h44);
    t2 = cyc;
    for (int k = 0; k < 4000 * FCLK && cyc < t_first + 2700 * FCLK; k++)
      @(negedge clk);
    chk("restart_busy", busy, 1);
    for (int k = 0; k < 4000 * FCLK && busy; k++) @(negedge clk);
    tfall = cyc;
    chk("conv_done", busy, 0);
    chk("conv_len", ((tfall - t2) / FCLK >= 2400 &&
                     (tfall - t2) / FCLK <= 2500) ? 1 : 0, 1);
    temp_data = 16'hABCD;
    oe_cnt = 0;
    read_bit(b);
    chk("idle_rd", b, 1);
    chk("idle_oe", oe_cnt, 0);

    reset_ok("rst_c");
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 9; i++) begin
      read_byte(v);
      chk($sformatf("sp%0d", i), v, exp_sp[i]);
    end
    read_bit(b);
    chk("post_rd", b, 1);

    reset_ok("rst_d");
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 20; i++) read_bit(b);
    reset_ok("rst_mid");
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(v);
    chk("restart_b0", v, 8'h91);

    reset_ok("rst_e");
    write_byte(8'h33);
    oe_cnt = 0;
    write_byte(8'hBE);
    read_byte(v);
    chk("rom33_rd", v, 8'hFF);
    chk("rom33_oe", oe_cnt, 0);
    chk("rom33_cmd", cmd_byte, 8'hBE);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
